fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the byte FIFO among four producer agents. It grants one producer per write, drives the FIFO's `wr_en`/`fifo_data`, and throttles all writes with high/low occupancy watermarks (hysteresis) taken from the FIFO's `fifo_words` count. It sits between the producer agents and the FIFO write port; the FIFO read side runs independently.

## Interface
- `DATA_W`, default 8: FIFO word width.
- `COUNT_W`, default 4: width of `fifo_words`.
- `HIGH_WM`, default 5: writes stop once estimated occupancy ≥ HIGH_WM.
- `LOW_WM`, default 2: writes resume once estimated occupancy ≤ LOW_WM. Legal values require 0 ≤ LOW_WM < HIGH_WM ≤ 2^COUNT_W−1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input 4: per-producer request. Held high with data stable until acked.
- `req_data` input 4*DATA_W: producer i's word is at bits [i*DATA_W +: DATA_W].
- `fifo_words` input COUNT_W: current FIFO occupancy.
- `ack` output 4: registered one-hot pulse. One cycle long, coincident with the write.
- `grant_id` output 2: index of the last granted producer.
- `wr_en` output 1: registered FIFO write enable.
- `fifo_data` output DATA_W: registered FIFO write data.
- `throttled` output 1: high while in HOLD.

## Operation
- States: RESET, FILL, HOLD. All state, outputs, and the round-robin pointer `rr_ptr` (2 bits) are registered.
- RESET is entered asynchronously whenever rst_n is low.
  - Outputs during reset: wr_en=0, ack=0, fifo_data=0, grant_id=0, throttled=0, rr_ptr=0.
  - On the first edge with rst_n high, the state moves to FILL. No grant is issued on that edge.
- Occupancy estimate: occ = fifo_words + wr_en, computed COUNT_W+1 bits wide, so it cannot overflow. This counts the write in flight that the FIFO captures on the current edge.
- FILL, evaluated each edge:
  - If occ ≥ HIGH_WM: go to HOLD and issue no grant this edge.
  - Otherwise, form the eligible set = req & ~ack. A requester whose ack is high this cycle is masked.
  - If the eligible set is non-empty, pick the first eligible index starting at rr_ptr, searching upward with wrap 3→0. Then set ack[i]=1, wr_en=1, fifo_data=req_data[i], grant_id=i, rr_ptr=(i+1) mod 4.
  - If the eligible set is empty: wr_en=0 and ack=0.
- HOLD, evaluated each edge:
  - wr_en=0, ack=0, throttled=1.
  - If occ ≤ LOW_WM: go to FILL (throttled=0). The first grant happens on the following edge.
- fifo_data and grant_id hold their last values when wr_en=0.
- Producer protocol: a producer samples ack at the edge that ends the ack cycle. It then either drops req or presents the next word. The arbiter never double-writes the same word.

## Timing
- Grant latency: a request present before edge E is acked and written in the cycle after E, when eligible and in FILL with occ < HIGH_WM.
- A single active producer gets at most one write every 2 cycles, because of the ack mask. With two or more producers active, one write per cycle is possible.
- With HIGH_WM=5, no read traffic and continuous requests, the FIFO stops at exactly 5 words with no overshoot.
- Throttle reaction: HOLD is entered on the edge where occ first reaches HIGH_WM. wr_en is low in the following cycle.
- Resume: 1 edge to return to FILL, then 1 edge to the first grant.
- Reset mid-write: ack and wr_en drop immediately, asynchronously. The interrupted word counts as not written. The producer must keep req high.
- Simultaneous requests: only one grant per edge. Non-granted producers wait.

## Test plan
- Reset: hold rst_n low for 3 cycles with all req high.
  - Required: all outputs are 0 during reset.
  - Required: the first wr_en appears in the cycle after the 2nd edge following release, with ack=0001.
- Single producer 0: continuous requests with data 0x10, 0x11, …, into a depth-8 FIFO model with no reads.
  - Required: wr_en pulses on alternate cycles and writes 0x10–0x14.
  - Required: throttled=1 with fifo_words=5, never 6.
- All four producers requesting, with occupancy held at 0.
  - Required: grant_id sequence 0,1,2,3,0,1 on consecutive cycles, with ack one-hot and matching.
- Hysteresis: fill to 5, then a reader drains 1 word per 4 cycles.
  - Required: throttled stays 1 at occupancy 4 and 3.
  - Required: at occupancy 2, throttled drops after 1 edge, and wr_en rises 1 edge later.
- Wrap: rr_ptr=3 (after a grant to producer 2), with req=1010.
  - Required: grant to 3, then to 1, then to 3.
- Async reset asserted while ack=0100 and wr_en=1.
  - Required: ack, wr_en and throttled drop before the next edge.
  - Required: after release, the first grant goes to the lowest requesting index (rr_ptr=0).

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of one FIFO write port among four producers, throttled by occupancy watermarks
module fifo_write_arbiter #(
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 4,
  parameter int HIGH_WM = 5,
  parameter int LOW_WM  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] req_data,
  input  logic [COUNT_W-1:0]  fifo_words,
  output logic [3:0]          ack,
  output logic [1:0]          grant_id,
  output logic                wr_en,
  output logic [DATA_W-1:0]   fifo_data,
  output logic                throttled
);
  typedef enum logic [1:0] {RESET, FILL, HOLD} state_t;
  localparam logic [COUNT_W:0] HI = (COUNT_W+1)'(HIGH_WM);
  localparam logic [COUNT_W:0] LO = (COUNT_W+1)'(LOW_WM);
  state_t           state;
  logic [1:0]       rr_ptr, pick;
  logic             found;
  logic [3:0]       elig;
  logic [COUNT_W:0] occ;
  // the word being written this cycle lands on the coming edge, so count it now
  assign occ  = {1'b0, fifo_words} + (COUNT_W+1)'(wr_en);
  assign elig = req & ~ack;
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    for (int k = 3; k >= 0; k--)
      if (elig[rr_ptr + 2'(k)]) begin
        pick  = rr_ptr + 2'(k);
        found = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= RESET;
      ack       <= '0;
      wr_en     <= 1'b0;
      fifo_data <= '0;
      grant_id  <= '0;
      throttled <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      ack   <= '0;
      wr_en <= 1'b0;
      case (state)
        RESET: state <= FILL;
        FILL:
          if (occ >= HI) begin
            state     <= HOLD;
            throttled <= 1'b1;
          end else if (found) begin
            ack       <= 4'b0001 << pick;
            wr_en     <= 1'b1;
            fifo_data <= req_data[pick*DATA_W +: DATA_W];
            grant_id  <= pick;
            rr_ptr    <= pick + 2'd1;
          end
        HOLD:
          if (occ <= LO) begin
            state     <= FILL;
            throttled <= 1'b0;
          end
        default: state <= RESET;
      endcase
    end
endmodule
